// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the digit-serial multiplier built on an 8x8 signed core.
package mult_seq_pkg;
    localparam int DIGIT_W = 7;
    localparam int MUL_W   = 8;

    typedef enum logic [1:0] {IDLE, MUL, DONE} mult_state_t;
endpackage

// File: rtl/hlr_bm2.sv
// Combinational 8x8 signed multiplier producing an exact 16-bit product.
module hlr_bm2 (
    input  logic signed [7:0]  a,
    input  logic signed [7:0]  b,
    output logic signed [15:0] p
);
    assign p = a * b;
endmodule

// File: rtl/mult_seq_via8.sv
// Sequential 2*WIDTH-bit signed/unsigned multiply(-accumulate) that walks all
// 7-bit digit pairs through one shared 8x8 signed multiplier, one pair per clock.
module mult_seq_via8
    import mult_seq_pkg::*;
#(
    parameter  int DIGITS = 3,
    localparam int WIDTH  = DIGIT_W * DIGITS
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic               i_signed,
    input  logic               i_mac,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_z
);
    localparam int ZW    = 2 * WIDTH;
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    mult_state_t state, state_nx;

    logic [WIDTH-1:0] a_r, b_r;
    logic             s_r;
    logic [IDX_W-1:0] ia, ib;
    logic [ZW-1:0]    acc, z;
    logic             rdy;

    logic                            accept, last;
    logic [DIGITS-1:0][MUL_W-1:0]    a_dig, b_dig;
    logic signed [2*MUL_W-1:0]       pp;
    logic [ZW-1:0]                   pp_ext, pp_sh, acc_sum;
    logic [IDX_W:0]                  dsum;

    assign accept  = i_valid && rdy;
    assign last    = (ia == LAST) && (ib == LAST);
    assign o_ready = rdy;
    assign o_valid = (state == DONE);
    assign o_z     = z;

    // Only the top digit carries the sign; lower digits are always non-negative.
    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        if (k == DIGITS - 1) begin : g_top
            assign a_dig[k] = {s_r & a_r[WIDTH-1], a_r[DIGIT_W*k +: DIGIT_W]};
            assign b_dig[k] = {s_r & b_r[WIDTH-1], b_r[DIGIT_W*k +: DIGIT_W]};
        end else begin : g_low
            assign a_dig[k] = {1'b0, a_r[DIGIT_W*k +: DIGIT_W]};
            assign b_dig[k] = {1'b0, b_r[DIGIT_W*k +: DIGIT_W]};
        end
    end

    hlr_bm2 u_mul (
        .a (a_dig[ia]),
        .b (b_dig[ib]),
        .p (pp)
    );

    assign dsum    = {1'b0, ia} + {1'b0, ib};
    assign pp_ext  = {{(ZW-2*MUL_W){pp[2*MUL_W-1]}}, pp};
    assign pp_sh   = pp_ext << (DIGIT_W * dsum);
    assign acc_sum = acc + pp_sh;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)  state_nx = MUL;
            MUL:     if (last)    state_nx = DONE;
            DONE:    if (i_ready) state_nx = IDLE;
            default:              state_nx = IDLE;
        endcase
    end

    // Ready is registered so it stays low throughout reset without an input-to-output path.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            rdy   <= 1'b0;
        end else begin
            state <= state_nx;
            rdy   <= (state_nx == IDLE);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_r <= '0;
            b_r <= '0;
            s_r <= 1'b0;
            ia  <= '0;
            ib  <= '0;
            acc <= '0;
            z   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a_r <= i_a;
                    b_r <= i_b;
                    s_r <= i_signed;
                    acc <= i_mac ? z : '0;
                    ia  <= '0;
                    ib  <= '0;
                end
                MUL: begin
                    acc <= acc_sum;
                    if (last) begin
                        ia <= '0;
                        ib <= '0;
                        z  <= acc_sum;
                    end else if (ib == LAST) begin
                        ib <= '0;
                        ia <= ia + 1'b1;
                    end else begin
                        ib <= ib + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
